// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with runtime parity/stop config.
// Define UART_TX_BREAK_EN to add the i_break input that holds the idle line low.
module uart_tx_buffered #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int BAUD_RATE     = 3_000_000,
   parameter int NUM_DATA_BITS = 8,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_tx_valid,
   input  logic [NUM_DATA_BITS-1:0]     i_tx_data,
   output logic                         o_tx_ready,
   input  logic                         i_parity_en,
   input  logic                         i_parity_odd,
   input  logic                         i_two_stop,
`ifdef UART_TX_BREAK_EN
   input  logic                         i_break,
`endif
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
   output logic                         o_busy,
   output logic                         o_tx
);
   localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int CW  = $clog2(DIV + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int BW  = $clog2(NUM_DATA_BITS + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                   state;
   logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [NUM_DATA_BITS-1:0] head;
   logic [NUM_DATA_BITS-1:0] shreg;
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [AW:0]              count;
   logic [CW-1:0]            cnt;
   logic [BW-1:0]            bit_idx;
   logic                     ne_q, avail, go, push, pop, bit_end, frame_end;
   logic                     par_en, par_bit, two_stop, stop_idx, tx_q;

   assign o_tx_ready   = count != (AW + 1)'(FIFO_DEPTH);
   assign o_fifo_count = count;
   assign o_busy       = state != IDLE || count != '0;
   assign head         = mem[rd_ptr];
   assign push         = i_tx_valid && o_tx_ready;
   // The FSM sees a new entry one cycle after it lands, giving a two-edge write-to-start latency.
   assign avail        = ne_q && count != '0;
   assign bit_end      = cnt == CW'(DIV - 1);
   assign frame_end    = bit_end && (stop_idx || !two_stop);
   assign pop          = go && (state == IDLE || (state == STOP && frame_end));

`ifdef UART_TX_BREAK_EN
   assign go   = avail && !i_break;
   assign o_tx = tx_q && !(i_break && state == IDLE);
`else
   assign go   = avail;
   assign o_tx = tx_q;
`endif

   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= i_tx_data;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ne_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         ne_q <= count != '0;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state    <= IDLE;
         tx_q     <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         two_stop <= 1'b0;
         stop_idx <= 1'b0;
      end else begin
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
         if (pop) begin
            state    <= START;
            tx_q     <= 1'b0;
            shreg    <= head;
            par_en   <= i_parity_en;
            par_bit  <= ^head ^ i_parity_odd;
            two_stop <= i_two_stop;
         end else begin
            case (state)
               IDLE: tx_q <= 1'b1;
               START:
                  if (bit_end) begin
                     state   <= DATA;
                     tx_q    <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= '0;
                  end
               DATA:
                  if (bit_end) begin
                     if (bit_idx == BW'(NUM_DATA_BITS - 1)) begin
                        state    <= par_en ? PARITY : STOP;
                        tx_q     <= par_en ? par_bit : 1'b1;
                        stop_idx <= 1'b0;
                     end else begin
                        tx_q    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end
               PARITY:
                  if (bit_end) begin
                     state    <= STOP;
                     tx_q     <= 1'b1;
                     stop_idx <= 1'b0;
                  end
               STOP:
                  if (bit_end) begin
                     stop_idx <= 1'b1;
                     if (frame_end) state <= IDLE;
                  end
               default: begin
                  state <= IDLE;
                  tx_q  <= 1'b1;
               end
            endcase
         end
      end
endmodule
